fft_bitrev_buffer_3: RTL and testbench

Ping-pong reorder buffer upstream of the radix-2 FFT butterfly stages. It accepts a stream of complex 12-bit samples in natural order, 16 samples per frame. It emits each frame in bit-reversed order so the first butterfly stage can consume adjacent pairs directly. Two banks let one frame fill while the previous frame drains, so sustained throughput is one sample per clock.

---
 rtl/fft_3_pkg.sv | 26 ++
 rtl/fft_bank_ram_3.sv | 34 +++
 rtl/fft_bitrev_buffer_3.sv | 144 ++++++++++++++
 tb/tb_fft_bitrev_buffer_3.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_3_pkg.sv
// Shared definitions for the bit-reversal reorder buffer.
//   DefW / DefN / DefLog2N : default sample width, frame length and index width
//   bank_state_e           : lifecycle of one ping-pong bank
//   bitrev()               : reverses a DefLog2N-bit index
package fft_3_pkg;

    localparam int unsigned DefW     = 12;
    localparam int unsigned DefN     = 16;
    localparam int unsigned DefLog2N = 4;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_e;

    function automatic logic [DefLog2N-1:0] bitrev(input logic [DefLog2N-1:0] k);
        logic [DefLog2N-1:0] r;
        for (int i = 0; i < DefLog2N; i++) begin
            r[i] = k[DefLog2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram_3.sv
// Simple dual-port memory holding both ping-pong banks (bank select is the address MSB).
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : combinational read data
module fft_bank_ram_3
    import fft_3_pkg::*;
#(
    parameter int unsigned DataW = 2 * DefW,
    parameter int unsigned Depth = 2 * DefN,
    parameter int unsigned AddrW = DefLog2N + 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [DataW-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [DataW-1:0] rd_data
);

    logic [DataW-1:0] mem [Depth];

    // Contents are deliberately not reset; bank state decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_bitrev_buffer_3.sv
// Ping-pong reorder buffer: accepts complex samples in natural order and emits each
// frame in bit-reversed order, one sample per clock sustained.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_real/in_img : input stream (natural order)
//   out_valid/out_ready              : output handshake
//   out_real/out_img                 : output sample (bit-reversed order)
//   out_index                        : read address of the output within the frame
//   out_last                         : final sample of a frame
// LOG2N must equal DefLog2N because bitrev() is sized from the package.
module fft_bitrev_buffer_3
    import fft_3_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned N     = DefN,
    parameter int unsigned LOG2N = DefLog2N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_real,
    input  logic [W-1:0]     in_img,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_real,
    output logic [W-1:0]     out_img,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last
);

    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_real_q, out_real_d;
    logic [W-1:0]     out_img_q, out_img_d;
    logic [LOG2N-1:0] out_index_q, out_index_d;

    logic             wr_fire;
    logic             load_en;
    logic             bank_has_data;
    logic             rd_load;
    logic [LOG2N-1:0] wr_addr_rev;
    logic [2*W-1:0]   rd_data;

    // Registered bank state only, so a bank freed this cycle is never written this cycle.
    assign in_ready      = (bank_q[wr_ptr_q] == BankEmpty) || (bank_q[wr_ptr_q] == BankFilling);
    assign wr_fire       = in_valid && in_ready;
    assign load_en       = !out_valid_q || out_ready;
    assign bank_has_data = (bank_q[rd_ptr_q] == BankFull) || (bank_q[rd_ptr_q] == BankDraining);
    assign rd_load       = load_en && bank_has_data;
    assign wr_addr_rev   = bitrev(wr_cnt_q);

    fft_bank_ram_3 #(
        .DataW (2 * W),
        .Depth (2 * N),
        .AddrW (LOG2N + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr ({wr_ptr_q, wr_addr_rev}),
        .wr_data ({in_real, in_img}),
        .rd_addr ({rd_ptr_q, rd_cnt_q}),
        .rd_data (rd_data)
    );

    // Write and read updates always target different banks (FILLING/EMPTY vs
    // FULL/DRAINING), so both may land in the same cycle.
    always_comb begin
        bank_d      = bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_real_d  = out_real_q;
        out_img_d   = out_img_q;
        out_index_d = out_index_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == LastIdx) begin
                bank_d[wr_ptr_q] = BankFull;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                bank_d[wr_ptr_q] = BankFilling;
            end
        end

        if (load_en) begin
            out_valid_d = bank_has_data;
        end

        if (rd_load) begin
            out_real_d  = rd_data[2*W-1:W];
            out_img_d   = rd_data[W-1:0];
            out_index_d = rd_cnt_q;
            rd_cnt_d    = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LastIdx) begin
                bank_d[rd_ptr_q] = BankEmpty;
                rd_ptr_d         = ~rd_ptr_q;
            end else begin
                bank_d[rd_ptr_q] = BankDraining;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]   <= BankEmpty;
            bank_q[1]   <= BankEmpty;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_img_q   <= '0;
            out_index_q <= '0;
        end else begin
            bank_q      <= bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_img_q   <= out_img_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_img   = out_img_q;
    assign out_index = out_index_q;
    assign out_last  = (out_index_q == LastIdx);

endmodule

// File: tb/tb_fft_bitrev_buffer_3.sv
// Self-checking bench for fft_bitrev_buffer_3: randomized and directed stimulus against a
// frame-level reference model (collect N natural-order samples, emit them bit-reversed).
module tb_fft_bitrev_buffer_3;

    localparam int W     = 12;
    localparam int N     = 16;
    localparam int LOG2N = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_real;
    logic [W-1:0]     in_img;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_real;
    logic [W-1:0]     out_img;
    logic [LOG2N-1:0] out_index;
    logic             out_last;

    fft_bitrev_buffer_3 #(
        .W     (W),
        .N     (N),
        .LOG2N (LOG2N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_img    (in_img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_img   (out_img),
        .out_index (out_index),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           idx;
        int           avail;
    } item_t;

    item_t        exp_q [$];
    logic [W-1:0] fr_re [N];
    logic [W-1:0] fr_im [N];
    int           fr_cnt = 0;
    int           n_cmp  = 0;
    int           n_err  = 0;
    int           n_acc  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_bitrev(input int j);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = r * 2 + ((j >> i) & 1);
        return r;
    endfunction

    // Output register holds the oldest sample once its frame has been complete one cycle.
    function automatic logic model_valid();
        return (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    endfunction

    // Input is refused only when two complete frames still have samples not yet loaded.
    function automatic logic model_ready();
        int r;
        r = exp_q.size() - (model_valid() ? 1 : 0);
        return ((r + N - 1) / N) < 2;
    endfunction

    task automatic check_outputs();
        logic v;
        v = model_valid();
        check_eq("out_valid", out_valid, v);
        if (v) begin
            check_eq("out_real", out_real, exp_q[0].re);
            check_eq("out_img", out_img, exp_q[0].im);
            check_eq("out_index", out_index, exp_q[0].idx);
            check_eq("out_last", out_last, exp_q[0].idx == N - 1);
        end
    endtask

    // One clock: entered and left at a falling edge.
    task automatic step(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic ordy);
        check_outputs();
        in_valid  = v;
        in_real   = re;
        in_img    = im;
        out_ready = ordy;
        #1;
        check_eq("in_ready", in_ready, model_ready());
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) begin
            n_acc++;
            fr_re[fr_cnt] = in_real;
            fr_im[fr_cnt] = in_img;
            fr_cnt++;
            if (fr_cnt == N) begin
                for (int j = 0; j < N; j++) begin
                    exp_q.push_back('{re: fr_re[ref_bitrev(j)], im: fr_im[ref_bitrev(j)],
                                      idx: j, avail: cyc + 2});
                end
                fr_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        int start;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_real   = '0;
        in_img    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_real", out_real, 0);
        check_eq("rst_out_img", out_img, 0);
        check_eq("rst_out_index", out_index, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_in_ready", in_ready, 1);

        // Single frame, k / -k
        for (int k = 0; k < N; k++) step(1'b1, W'(k), W'(-k), 1'b1);
        idle(20);

        // Four back-to-back frames
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < N; k++) step(1'b1, W'(f * 16 + k), W'(1000 + f * 16 + k), 1'b1);
        end
        idle(24);

        // Backpressure: both banks fill, then drain
        start = n_acc;
        for (int i = 0; i < 2 * N + 8; i++) step(1'b1, W'(i + 50), W'(i + 70), 1'b0);
        check_eq("bp_accepted", n_acc - start, 2 * N);
        idle(2 * N + 8);

        // Random valid/ready over 20 frames
        start = n_acc;
        guard = 0;
        while (n_acc - start < 20 * N && guard < 4000) begin
            step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                 1'($urandom_range(0, 1)));
            guard++;
        end
        check_eq("rand_accepted", n_acc - start, 20 * N);
        idle(2 * N + 8);

        // Reset mid-frame with a sample waiting in the output register
        for (int k = 0; k < N; k++) step(1'b1, W'(k + 100), W'(k + 200), 1'b0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b1, W'(k + 300), W'(k + 400), 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_real", out_real, 0);
        check_eq("mid_rst_out_img", out_img, 0);
        check_eq("mid_rst_out_index", out_index, 0);
        check_eq("mid_rst_out_last", out_last, 0);
        exp_q.delete();
        fr_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) step(1'b1, W'(k + 500), W'(k + 600), 1'b1);
        idle(24);

        // Extremes: 0x7FF / 0x800 alternating
        for (int k = 0; k < 2 * N; k++) begin
            if (k % 2 == 0) step(1'b1, 12'h7FF, 12'h800, 1'b1);
            else            step(1'b1, 12'h800, 12'h7FF, 1'b1);
        end
        idle(24);

        check_eq("all_drained", exp_q.size(), 0);
        check_eq("no_partial", fr_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
